// File: rtl/finv_table_arbiter.sv
// rtl/finv_table_arbiter.sv - round-robin arbiter sharing one registered finv lookup table among NREQ requesters
module finv_table_arbiter #(
    parameter int NREQ      = 2,
    parameter int KEY_W     = 10,
    parameter int VAL_W     = 36,
    parameter int TABLE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*KEY_W-1:0] req_key,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [VAL_W-1:0]      resp_value,
    output logic [KEY_W-1:0]      table_key,
    input  logic [VAL_W-1:0]      table_value,
    output logic [1:0]            inflight
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic             found;
    logic [NREQ-1:0]  accepted;
    logic             accept;
    logic [NREQ-1:0]  tag_pipe [TABLE_LAT];

    // Priority scan: distance k from rr_ptr, first valid requester wins.
    always_comb begin
        req_ready = '0;
        table_key = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && req_valid[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
                        found        = 1'b1;
                        req_ready[i] = 1'b1;
                        grant_idx    = PTR_W'(i);
                        table_key    = req_key[i*KEY_W +: KEY_W];
                    end
                end
            end
        end
    end

    assign accepted = req_ready & req_valid;
    assign accept   = |accepted;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            resp_valid <= '0;
            resp_value <= '0;
            inflight   <= '0;
            for (int s = 0; s < TABLE_LAT; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + PTR_W'(1);
            end

            // Tags travel alongside the table read so the response lands with its data.
            tag_pipe[0] <= accepted;
            for (int s = 1; s < TABLE_LAT; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end

            resp_valid <= tag_pipe[TABLE_LAT-1];
            if (|tag_pipe[TABLE_LAT-1]) begin
                resp_value <= table_value;
            end

            if (accept && !(|resp_valid)) begin
                inflight <= inflight + 2'd1;
            end else if (!accept && (|resp_valid)) begin
                inflight <= inflight - 2'd1;
            end
        end
    end

endmodule
